nios_screen_cmd_out: RTL and testbench
======================================

# nios_screen_cmd_out

Avalon-MM write-side companion to the screen data input port: the Nios core writes 16-bit screen command words into a small FIFO, and the block presents them on a valid/ready stream to the screen controller. It sits on the Nios data bus as a 4-word slave and provides status, overflow detection, flush and an empty interrupt, so software can burst commands without polling per word.

## Interface
Parameters:
- DATA_W, 16, width of command word and out_data
- DEPTH, 8, FIFO depth in words; power of two, 2..64
- LVL_W, clog2(DEPTH)+1, width of fill-level field

Ports:
- clk  in  1  clock; all state on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- address  in  2  word address of register
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe, qualified by chipselect
- writedata  in  32  write data
- readdata  out  32  registered read data
- out_data  out  DATA_W  FIFO head word
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  downstream accepts out_data when high with out_valid
- irq  out  1  level interrupt

## Operation
- Register map (write = chipselect & !write_n):
  - addr 0 DATA: write pushes writedata[DATA_W-1:0]; upper bits ignored. Read returns {zeros, out_data} (0 when empty).
  - addr 1 STATUS: read bit0 empty, bit1 full, bit2 overflow (sticky), bits[8+LVL_W-1:8] level, rest 0. Write: bit0=1 flushes FIFO; bit2=1 clears overflow; other bits ignored.
  - addr 2 CONTROL: bit0 irq_en, R/W; other bits read 0.
  - addr 3: reads 0, writes ignored.
- FIFO: show-ahead; out_data = mem[rd_ptr] from registers, out_valid = (level != 0). Pointers wrap modulo DEPTH; level 0..DEPTH.
- Pop when out_valid & out_ready. Push when DATA write & !full.
- Push while full (judged on pre-edge level): word dropped, overflow set, even if a pop occurs same cycle. Level after: level-1 if popped.
- Push and pop same cycle, not full: level unchanged, both pointers advance.
- Flush: rd_ptr=wr_ptr=0, level=0 next cycle; overrides any same-cycle pop; out_valid low next cycle. Flush and overflow-clear may be combined in one write.
- Overflow set and clear in the same cycle: set wins.
- irq = irq_en & empty, registered from post-update state.
- Reset: readdata 0, out_valid 0, out_data 0 (mem cleared not required, but out_data must read 0 while empty), level 0, pointers 0, overflow 0, irq_en 0, irq 0.

## Timing
- Every cycle: readdata <= mux(address, pre-edge state). Read latency 1 cycle, no waitstates; reads have no side effects.
- Write at edge N: level, out_valid, full/empty, and CONTROL update after edge N. A read whose address is sampled at edge N+1 reflects the write.
- irq lags the empty/irq_en change by one cycle (registered).
- out_data stable while out_valid & !out_ready; next word visible the cycle after a pop.
- Peak throughput: 1 push and 1 pop per cycle.
- Reset assertion mid-transfer clears state immediately (asynchronous); out_valid low without waiting for the clock.

## Test plan
- Reset, then read addr1 -> readdata 0x00000001 (empty), out_valid 0, irq 0.
- Write 0x1234, 0xABCD to addr0, out_ready=0 -> out_valid 1, out_data 0x1234; STATUS level 2. Raise out_ready 2 cycles -> 0x1234 then 0xABCD accepted, out_valid 0.
- DEPTH+1 writes with out_ready=0 -> full=1, level=DEPTH, overflow=1; drain returns first DEPTH words in order, extra word absent. Write 0x4 to addr1 -> overflow 0.
- Full FIFO, same-cycle DATA write and pop -> write dropped, overflow 1, level DEPTH-1.
- Write 3 words, write 0x1 to addr1 with out_ready=1 -> level 0 next cycle, no further words delivered; pointer wrap verified by 3*DEPTH streamed words matching in order.
- Write 0x1 to addr2 with FIFO empty -> irq 1 one cycle later; push a word -> irq 0; assert reset_n low mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/nios_screen_cmd_out.sv
// Avalon-MM slave that buffers 16-bit screen command words from the Nios core
// in a show-ahead FIFO and streams them out on a valid/ready interface.
// Registers: 0 DATA, 1 STATUS, 2 CONTROL, 3 reserved.
module nios_screen_cmd_out #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              irq
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              ovf_q, ovf_d;
    logic              irq_en_q, irq_en_d;
    logic              irq_q;
    logic [31:0]       readdata_q, readdata_d;

    logic wr_en, push_req, push, pop, flush, ovf_set, ovf_clr;
    logic empty, full;

    // Only the low command word and STATUS/CONTROL bits 0 and 2 carry meaning.
    logic unused_wdata;
    assign unused_wdata = ^{writedata[31:3], writedata[1]};

    assign empty     = (level_q == '0);
    assign full      = (level_q == LVL_W'(DEPTH));
    assign out_valid = !empty;
    // Gate the head word so stale memory never shows while the FIFO is empty.
    assign out_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign readdata  = readdata_q;
    assign irq       = irq_q;

    // Decode bus writes and compute the next FIFO / register state.
    always_comb begin
        wr_en    = chipselect && !write_n;
        push_req = wr_en && (address == 2'd0);
        push     = push_req && !full;
        pop      = out_valid && out_ready;
        flush    = wr_en && (address == 2'd1) && writedata[0];
        ovf_clr  = wr_en && (address == 2'd1) && writedata[2];
        ovf_set  = push_req && full;

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end

        // Set has priority over a same-cycle clear.
        ovf_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

        irq_en_d = irq_en_q;
        if (wr_en && (address == 2'd2)) irq_en_d = writedata[0];
    end

    // Register read mux, sampled from pre-edge state every cycle.
    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0: readdata_d[DATA_W-1:0] = out_data;
            2'd1: begin
                readdata_d[0]          = empty;
                readdata_d[1]          = full;
                readdata_d[2]          = ovf_q;
                readdata_d[8 +: LVL_W] = level_q;
            end
            2'd2:    readdata_d[0] = irq_en_q;
            default: readdata_d = '0;
        endcase
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_en_q && empty;
            readdata_q <= readdata_d;
        end
    end

    // FIFO storage; contents need no reset because out_data is gated by empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= writedata[DATA_W-1:0];
    end

endmodule

// File: tb/tb_nios_screen_cmd_out.sv
// Scoreboard bench: stimulus pushes expected stream words into a queue, a
// negedge monitor pops and compares on every valid/ready handshake.
module tb_nios_screen_cmd_out;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned LVL_W  = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              irq;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DATA_W-1:0] exp_q[$];

    nios_screen_cmd_out #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every accepted word must match the scoreboard head.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL stream_extra: got 0x%04h expected no word", out_data);
            end else begin
                chk("stream_word", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic bus_rd(input logic [1:0] a, input string name, input logic [31:0] exp);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        tick();
        chipselect = 1'b0;
        chk(name, readdata, exp);
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int k = 0; k < 100 && (exp_q.size() != 0 || out_valid); k++) tick();
        out_ready = 1'b0;
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_readdata", readdata, 32'd0);
        reset_n = 1'b1;
        tick();

        // Reset register state
        bus_rd(2'd1, "status_reset", 32'h0000_0001);
        bus_rd(2'd0, "data_empty", 32'h0);
        bus_rd(2'd2, "ctrl_reset", 32'h0);
        bus_rd(2'd3, "addr3", 32'h0);

        // Two words, held while out_ready low; upper writedata bits ignored
        bus_wr(2'd0, 32'hFFFF_1234); exp_q.push_back(16'h1234);
        bus_wr(2'd0, 32'h0000_ABCD); exp_q.push_back(16'hABCD);
        chk("two_valid", 32'(out_valid), 32'd1);
        chk("two_head", 32'(out_data), 32'h1234);
        bus_rd(2'd1, "two_status", 32'h0000_0200);
        bus_rd(2'd0, "two_data", 32'h0000_1234);
        chk("two_head_stable", 32'(out_data), 32'h1234);
        drain("two_drain");
        chk("two_empty", 32'(out_valid), 32'd0);

        // Overflow: DEPTH+1 writes, last one dropped
        for (int i = 0; i <= int'(DEPTH); i++) begin
            bus_wr(2'd0, 32'h100 + 32'(i));
            if (i < int'(DEPTH)) exp_q.push_back(16'h100 + 16'(i));
        end
        bus_rd(2'd1, "ovf_status", 32'h0000_0806);
        // Full FIFO: write and pop same cycle -> write dropped, level DEPTH-1
        out_ready = 1'b1;
        bus_wr(2'd0, 32'hDEAD);
        out_ready = 1'b0;
        bus_rd(2'd1, "full_pushpop", 32'h0000_0704);
        bus_wr(2'd1, 32'h4);
        bus_rd(2'd1, "ovf_clear", 32'h0000_0700);
        drain("ovf_drain");

        // Flush with out_ready high; flush and overflow-clear combined
        bus_wr(2'd0, 32'h11); exp_q.push_back(16'h11);
        bus_wr(2'd0, 32'h22); exp_q.push_back(16'h22);
        bus_wr(2'd0, 32'h33); exp_q.push_back(16'h33);
        out_ready = 1'b1;
        bus_wr(2'd1, 32'h5);
        exp_q.delete();
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_data", 32'(out_data), 32'd0);
        repeat (4) tick();
        out_ready = 1'b0;
        bus_rd(2'd1, "flush_status", 32'h0000_0001);

        // Pointer wrap: 3*DEPTH words streamed at one push and one pop per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 3 * int'(DEPTH); i++) begin
            bus_wr(2'd0, 32'h5000 + 32'(i * 7));
            exp_q.push_back(16'h5000 + 16'(i * 7));
        end
        drain("wrap_drain");
        bus_rd(2'd1, "wrap_status", 32'h0000_0001);

        // Interrupt on empty with one-cycle lag
        bus_wr(2'd2, 32'h1);
        chk("irq_lag", 32'(irq), 32'd0);
        tick();
        chk("irq_set", 32'(irq), 32'd1);
        bus_rd(2'd2, "ctrl_rd", 32'h1);
        bus_wr(2'd0, 32'h77); exp_q.push_back(16'h77);
        chk("irq_hold", 32'(irq), 32'd1);
        tick();
        chk("irq_clr", 32'(irq), 32'd0);

        // Asynchronous reset mid-stream
        bus_wr(2'd0, 32'h88); exp_q.push_back(16'h88);
        address = 2'd0;
        tick();
        #2 reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data", 32'(out_data), 32'd0);
        chk("arst_irq", 32'(irq), 32'd0);
        chk("arst_readdata", readdata, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        bus_rd(2'd2, "post_rst_ctrl", 32'h0);
        bus_rd(2'd1, "post_rst_status", 32'h0000_0001);

        chk("queue_final", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
